// File: rtl/instr_fetch_unit.sv
// Instruction sequencer: owns pc, fetches from combinational instruction memory,
// decodes into register-file fields and issues them over valid/ready. Option macro: FETCH_LOOP_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 8,
  parameter int PROG_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_cs,
  input  logic [DATA_W-1:0] im_data,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [1:0]        r1_addr,
  output logic [1:0]        r2_addr,
  output logic [1:0]        wr_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic              at_last;
  logic              unused_ir_bit;

  assign at_last = (pc_reg == LAST_PC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= FETCH;
        end
        FETCH: begin
          ir_reg    <= im_data;
          state_reg <= stop ? IDLE : ISSUE;
        end
        ISSUE: begin
          // stop only takes effect together with a handshake so valid never drops unaccepted
          if (issue_ready) begin
            pc_reg <= at_last ? '0 : pc_reg + 1'b1;
            if (stop)
              state_reg <= IDLE;
            else if (at_last)
`ifdef FETCH_LOOP_EN
              state_reg <= FETCH;
`else
              state_reg <= DONE;
`endif
            else
              state_reg <= FETCH;
          end
        end
        DONE: begin
          if (start) begin
            pc_reg    <= '0;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from registered state, so reset clears them at once
  assign im_addr     = pc_reg;
  assign pc          = pc_reg;
  assign im_cs       = (state_reg == FETCH);
  assign issue_valid = (state_reg == ISSUE);
  assign busy        = (state_reg == FETCH) || (state_reg == ISSUE);
  assign done        = (state_reg == DONE);

  assign r1_addr = issue_valid ? ir_reg[7:6] : 2'b00;
  assign r2_addr = issue_valid ? ir_reg[5:4] : 2'b00;
  assign wr_addr = issue_valid ? ir_reg[3:2] : 2'b00;
  assign rf_we   = issue_valid & ir_reg[1];

  // bit 0 of the instruction word is reserved
  assign unused_ir_bit = ir_reg[0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational program memory model.
// Checks reset, full program, backpressure, stop, rfe decode and wrap/done behaviour.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       issue_ready = 1'b0;
  logic [1:0] im_addr;
  logic       im_cs;
  logic [7:0] im_data;
  logic       issue_valid;
  logic [1:0] r1_addr, r2_addr, wr_addr;
  logic       rf_we;
  logic [1:0] pc;
  logic       busy, done;

  logic [7:0] prog [4];
  int total = 0;
  int bad   = 0;

  assign im_data = prog[im_addr];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(2), .DATA_W(8), .PROG_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .im_addr(im_addr), .im_cs(im_cs), .im_data(im_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .wr_addr(wr_addr), .rf_we(rf_we),
    .pc(pc), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic check_issue(input string tag, input logic [7:0] w);
    check({tag, ".valid"}, int'(issue_valid), 1);
    check({tag, ".r1"},    int'(r1_addr), int'(w[7:6]));
    check({tag, ".r2"},    int'(r2_addr), int'(w[5:4]));
    check({tag, ".wr"},    int'(wr_addr), int'(w[3:2]));
    check({tag, ".rfe"},   int'(rf_we),   int'(w[1]));
    check({tag, ".cs"},    int'(im_cs), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog[0] = 8'h24; prog[1] = 8'h84; prog[2] = 8'h60; prog[3] = 8'hB0;

    // reset state
    step(); step();
    check("rst.cs",    int'(im_cs), 0);
    check("rst.valid", int'(issue_valid), 0);
    check("rst.pc",    int'(pc), 0);
    check("rst.busy",  int'(busy), 0);
    check("rst.done",  int'(done), 0);
    check("rst.r1",    int'(r1_addr), 0);
    rst = 1'b0;
    step();
    check("idle.cs", int'(im_cs), 0);

    // full program, ready tied high
    issue_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("prog%0d.cs", i),    int'(im_cs), 1);
      check($sformatf("prog%0d.addr", i),  int'(im_addr), i);
      check($sformatf("prog%0d.rfe0", i),  int'(rf_we), 0);
      check($sformatf("prog%0d.busy", i),  int'(busy), 1);
      step();
      check_issue($sformatf("prog%0d", i), prog[i]);
      step();
    end
`ifdef FETCH_LOOP_EN
    check("wrap.cs",   int'(im_cs), 1);
    check("wrap.addr", int'(im_addr), 0);
    for (int k = 4; k < 20; k++) begin
      check($sformatf("loop%0d.addr", k), int'(im_addr), k % 4);
      step();
      check_issue($sformatf("loop%0d", k), prog[k % 4]);
      check($sformatf("loop%0d.done", k), int'(done), 0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loopstop.busy", int'(busy), 0);
`else
    check("end.done",  int'(done), 1);
    check("end.cs",    int'(im_cs), 0);
    check("end.valid", int'(issue_valid), 0);
    check("end.pc",    int'(pc), 0);
    check("end.busy",  int'(busy), 0);
    step();
    check("end.done_hold", int'(done), 1);
`endif

    // backpressure on the second instruction, stop pulse ignored while held
    start = 1'b1;
    step();
    start = 1'b0;
    check("bp.f0.addr", int'(im_addr), 0);
    step();
    check_issue("bp.i0", prog[0]);
    step();
    check("bp.f1.addr", int'(im_addr), 1);
    step();
    issue_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_issue($sformatf("bp.hold%0d", c), prog[1]);
      check($sformatf("bp.hold%0d.pc", c), int'(pc), 1);
      stop = (c == 2);
      step();
    end
    stop = 1'b0;
    issue_ready = 1'b1;
    check_issue("bp.accept", prog[1]);
    step();
    check("bp.f2.cs",   int'(im_cs), 1);
    check("bp.f2.addr", int'(im_addr), 2);

    // stop during FETCH at pc=2
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop.busy",  int'(busy), 0);
    check("stop.valid", int'(issue_valid), 0);
    check("stop.cs",    int'(im_cs), 0);
    check("stop.pc",    int'(pc), 2);
    step();
    check("stop.idle_cs", int'(im_cs), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart.cs",   int'(im_cs), 1);
    check("restart.addr", int'(im_addr), 2);
    step();
    check_issue("restart.i2", prog[2]);
    step();
    check("restart.f3.addr", int'(im_addr), 3);
    step();
    check_issue("restart.i3", prog[3]);
    step();
`ifdef FETCH_LOOP_EN
    stop = 1'b1;
    step();
    stop = 1'b0;
`else
    check("restart.done", int'(done), 1);
`endif

    // rfe decode
    prog[0] = 8'h06;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rfe.fetch.we", int'(rf_we), 0);
    check("rfe.fetch.cs", int'(im_cs), 1);
    issue_ready = 1'b0;
    step();
    check_issue("rfe.i0", 8'h06);
    step();
    check_issue("rfe.i0hold", 8'h06);
    issue_ready = 1'b1;
    step();
    check("rfe.f1.we",   int'(rf_we), 0);
    check("rfe.f1.addr", int'(im_addr), 1);
    step();
    check_issue("rst.mid.i1", prog[1]);
    issue_ready = 1'b0;

    // asynchronous reset while issuing
    rst = 1'b1;
    #1;
    check("arst.valid", int'(issue_valid), 0);
    check("arst.cs",    int'(im_cs), 0);
    check("arst.pc",    int'(pc), 0);
    check("arst.r1",    int'(r1_addr), 0);
    check("arst.wr",    int'(wr_addr), 0);
    step();
    rst = 1'b0;
    step();
    check("arst.idle.busy", int'(busy), 0);
    check("arst.idle.done", int'(done), 0);

    // start and stop together in IDLE still fetches
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop.cs",   int'(im_cs), 1);
    check("startstop.addr", int'(im_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
